spi_slave_resp: RTL

- Clock-domain SPI slave/responder: the receiving end of the 12-bit SPI link, run from the system clock instead of from sclk.
- Oversamples the master's sclk/cs/mosi, captures a WIDTH-bit LSB-first frame on mosi, and returns a preloaded WIDTH-bit word on miso in the same frame.
- Sits between the SPI pins and a register/FIFO client; replaces sclk-clocked slave logic in system-clock designs.

---
 rtl/spi_slave_resp.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_resp.sv
// SPI slave responder clocked from the system clock: oversamples sclk/cs/mosi, receives an
// LSB-first WIDTH-bit frame and returns a buffered (or default) word on miso in the same frame.
module spi_slave_resp #(
    parameter int unsigned      WIDTH       = 12,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] DEFAULT_TX  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] din,
    input  logic             newd,
    output logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             err,
    output logic             underrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_d1_q, cs_d1_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_fall, cs_fall, cs_rise, last_fall;

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, buf_q, buf_d, dout_q, dout_d;
    logic             full_q, full_d;
    logic             done_q, done_d, err_q, err_d, und_q, und_d;

    // Idle-level reset values keep release from looking like an sclk or cs edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_d1_q   <= 1'b0;
            cs_d1_q     <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_d1_q   <= sclk_s;
            cs_d1_q     <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_d1_q & ~sclk_s;
    assign cs_fall   = cs_d1_q & ~cs_s;
    assign cs_rise   = ~cs_d1_q & cs_s;
    assign last_fall = sclk_fall && (count_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A completing edge wins over a simultaneous cs rise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) state_d = StShift;
            end
            StShift: begin
                if (last_fall)    state_d = cs_rise ? StIdle : StWaitCs;
                else if (cs_rise) state_d = StIdle;
            end
            StWaitCs: begin
                if (cs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        miso     = (state_q == StShift) ? tx_q[0] : 1'b0;
        ready    = ~full_q;
        dout     = dout_q;
        done     = done_q;
        err      = err_q;
        underrun = und_q;
    end

    always_comb begin
        count_d = count_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        buf_d   = buf_q;
        full_d  = full_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        und_d   = 1'b0;
        if (newd && !full_q) begin
            buf_d  = din;
            full_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    count_d = '0;
                    if (full_q) begin
                        tx_d   = buf_q;
                        full_d = 1'b0;
                    end else begin
                        tx_d  = DEFAULT_TX;
                        und_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (sclk_fall) begin
                    rx_d    = {mosi_s, rx_q[WIDTH-1:1]};
                    tx_d    = {1'b0, tx_q[WIDTH-1:1]};
                    count_d = count_q + CW'(1);
                end
                if (last_fall) begin
                    dout_d = rx_d;
                    done_d = 1'b1;
                end else if (cs_rise) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
            und_q   <= und_d;
        end
    end

endmodule
